// File: rtl/top_level_module_pkg.sv
// Shared types and constants for the traffic-light controller:
// phase enum, default phase durations and active-low 7-segment codes.
package top_level_module_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED1   = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED2   = 3'd5
  } state_e;

  localparam int DEF_GREEN_S  = 10;
  localparam int DEF_YELLOW_S = 3;
  localparam int DEF_ALLRED_S = 1;

  // Segment order {dp,g,f,e,d,c,b,a}, low = lit; dp is always dark.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] seg_pattern(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic state_e next_state(input state_e s);
    case (s)
      NS_GREEN:  return NS_YELLOW;
      NS_YELLOW: return ALLRED1;
      ALLRED1:   return EW_GREEN;
      EW_GREEN:  return EW_YELLOW;
      EW_YELLOW: return ALLRED2;
      default:   return NS_GREEN;
    endcase
  endfunction

endpackage

// File: rtl/top_level_module_seven_seg_decoder.sv
// Maps one BCD digit to active-low segments; a blank request or a
// non-decimal code darkens the whole digit.
module seven_seg_decoder
  import top_level_module_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  assign o_seg = i_blank ? SEG_BLANK : seg_pattern(i_digit);

endmodule

// File: rtl/top_level_module.sv
// Two-road traffic-light controller with a 1 s time base, per-phase
// countdown and a 4-digit multiplexed display of remaining seconds.
module top_level_module
  import top_level_module_pkg::*;
#(
  parameter int ONE_SEC_CYCLES = 100_000_000,
  parameter int SCAN_CYCLES    = 100_000,
  parameter int GREEN_S        = DEF_GREEN_S,
  parameter int YELLOW_S       = DEF_YELLOW_S,
  parameter int ALLRED_S       = DEF_ALLRED_S
) (
  input  logic       clk,
  input  logic       rst,
  output logic       clock_1s,
  output logic [7:0] seg_display,
  output logic [7:0] leds,
  output logic [3:0] anode
);

  localparam int DIV_W  = (ONE_SEC_CYCLES > 1) ? $clog2(ONE_SEC_CYCLES) : 1;
  localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(ONE_SEC_CYCLES - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(ONE_SEC_CYCLES / 2);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [6:0] GREEN_D  = 7'(GREEN_S);
  localparam logic [6:0] YELLOW_D = 7'(YELLOW_S);
  localparam logic [6:0] ALLRED_D = 7'(ALLRED_S);

  function automatic logic [6:0] duration(input state_e s);
    case (s)
      NS_GREEN, EW_GREEN:   return GREEN_D;
      NS_YELLOW, EW_YELLOW: return YELLOW_D;
      default:              return ALLRED_D;
    endcase
  endfunction

  logic [DIV_W-1:0]  r_div_cnt;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [1:0]        r_digit_idx;
  state_e            r_state;
  logic [6:0]        r_remaining;

  logic              w_tick;
  state_e            w_state_nxt;
  logic [6:0]        w_remaining_nxt;
  logic [3:0]        w_digit;
  logic              w_blank;
  logic [3:0]        w_ones;
  logic [3:0]        w_tens;

  // Time base: one tick per second, square wave high in the first half.
  assign w_tick   = (r_div_cnt == DIV_LAST);
  assign clock_1s = (r_div_cnt < DIV_HALF);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= 2'd0;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= r_digit_idx + 2'd1;
    end else begin
      r_scan_cnt  <= r_scan_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= NS_GREEN;
      r_remaining <= GREEN_D;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  // NOTE: defaults first so every path assigns; a missing branch would
  // otherwise infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    if (w_tick) begin
      if (r_remaining == 7'd1) begin
        w_state_nxt     = next_state(r_state);
        w_remaining_nxt = duration(next_state(r_state));
      end else begin
        w_remaining_nxt = r_remaining - 7'd1;
      end
    end
  end

  // leds = {EW walk, NS walk, EW r/y/g, NS r/y/g}
  always_comb begin
    leds = 8'b0010_0100;
    case (r_state)
      NS_GREEN:  leds = 8'b0110_0001;
      NS_YELLOW: leds = 8'b0010_0010;
      EW_GREEN:  leds = 8'b1000_1100;
      EW_YELLOW: leds = 8'b0001_0100;
      default:   leds = 8'b0010_0100;
    endcase
  end

  assign w_ones = 4'(r_remaining % 7'd10);
  assign w_tens = 4'(r_remaining / 7'd10);
  assign anode  = ~(4'b0001 << r_digit_idx);

  always_comb begin
    w_digit = 4'd0;
    w_blank = 1'b1;
    case (r_digit_idx)
      2'd0: begin
        w_digit = w_ones;
        w_blank = 1'b0;
      end
      2'd1: begin
        w_digit = w_tens;
        w_blank = (r_remaining < 7'd10);
      end
      2'd2: begin
        w_blank = 1'b0;
        case (r_state)
          NS_GREEN, NS_YELLOW: w_digit = 4'd1;
          EW_GREEN, EW_YELLOW: w_digit = 4'd2;
          default:             w_digit = 4'd0;
        endcase
      end
      default: w_blank = 1'b1;
    endcase
  end

  seven_seg_decoder u_dec (
    .i_digit (w_digit),
    .i_blank (w_blank),
    .o_seg   (seg_display)
  );

endmodule

// File: tb/tb_top_level_module.sv
// Self-checking bench: outputs are predicted from elapsed cycles since
// reset using the phase schedule, compared on the falling clock edge.
module tb_top_level_module;

  localparam int ONE_SEC = 10;
  localparam int SCAN    = 4;
  localparam int CYCLE_S = 28;
  localparam int          DUR    [6]  = '{10, 3, 1, 10, 3, 1};
  localparam logic [7:0]  LEDS   [6]  = '{8'h61, 8'h22, 8'h24, 8'h8C, 8'h14, 8'h24};
  localparam logic [3:0]  ANODES [4]  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [7:0]  SEG    [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  localparam logic [20:0] RESET_VEC = {8'h61, 8'hC0, 4'b1110, 1'b1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clock_1s;
  logic [7:0]  seg_display;
  logic [7:0]  leds;
  logic [3:0]  anode;
  int unsigned cyc;
  int          n_checks = 0;
  int          n_fail   = 0;

  top_level_module #(
    .ONE_SEC_CYCLES (ONE_SEC),
    .SCAN_CYCLES    (SCAN)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clock_1s    (clock_1s),
    .seg_display (seg_display),
    .leds        (leds),
    .anode       (anode)
  );

  always #5 clk = ~clk;

  // Elapsed clock edges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int phase_of(input int unsigned n, output int rem);
    int t, p, acc;
    t   = int'((n / ONE_SEC) % CYCLE_S);
    p   = 0;
    acc = 0;
    while (t >= acc + DUR[p]) begin
      acc += DUR[p];
      p++;
    end
    rem = DUR[p] - (t - acc);
    return p;
  endfunction

  function automatic logic [20:0] expect_out(input int unsigned n);
    int          rem, p;
    int unsigned idx;
    logic [7:0]  s;
    p   = phase_of(n, rem);
    idx = (n / SCAN) % 4;
    case (idx)
      0:       s = SEG[rem % 10];
      1:       s = (rem < 10) ? 8'hFF : SEG[rem / 10];
      2:       s = (p < 2) ? SEG[1] : ((p == 3 || p == 4) ? SEG[2] : SEG[0]);
      default: s = 8'hFF;
    endcase
    return {LEDS[p], s, ANODES[idx], ((n % ONE_SEC) < ONE_SEC / 2)};
  endfunction

  function automatic logic [20:0] actual();
    return {leds, seg_display, anode, clock_1s};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to(input int unsigned target);
    int g = 0;
    while (cyc < target && g < 2000) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (cyc != target) begin
      n_fail++;
      $display("FAIL run_to: cycle %0d, required %0d", cyc, target);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (actual() !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_hold: got %h, required %h", actual(), RESET_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (actual() !== RESET_VEC) begin
      n_fail++;
      $display("FAIL reset_release: got %h, required %h", actual(), RESET_VEC);
    end
  endtask

  task automatic test_divider();
    int          highs = 0;
    int unsigned last_rise = 0;
    int          rises = 0;
    logic        prev;
    do_reset();
    prev = clock_1s;
    repeat (40) begin
      @(negedge clk);
      n_checks++;
      if (clock_1s !== ((cyc % ONE_SEC) < ONE_SEC / 2)) begin
        n_fail++;
        $display("FAIL clock_1s: cycle %0d got %b", cyc, clock_1s);
      end
      if (clock_1s) highs++;
      if (clock_1s && !prev) begin
        if (rises > 0) begin
          n_checks++;
          if (cyc - last_rise != ONE_SEC) begin
            n_fail++;
            $display("FAIL tick_period: got %0d, required %0d", cyc - last_rise, ONE_SEC);
          end
        end
        last_rise = cyc;
        rises++;
      end
      prev = clock_1s;
    end
    n_checks++;
    if (highs != 20) begin
      n_fail++;
      $display("FAIL clock_duty: high %0d of 40, required 20", highs);
    end
  endtask

  task automatic test_full_cycle();
    int unsigned trans [6] = '{100, 130, 140, 240, 270, 280};
    logic [7:0]  nxt   [6] = '{8'h22, 8'h24, 8'h8C, 8'h14, 8'h24, 8'h61};
    logic [7:0]  prev_leds;
    int          k = 0;
    do_reset();
    prev_leds = leds;
    repeat (290) begin
      @(negedge clk);
      n_checks++;
      if (actual() !== expect_out(cyc)) begin
        n_fail++;
        $display("FAIL full_cycle: cycle %0d got %h, required %h", cyc, actual(), expect_out(cyc));
      end
      if (leds !== prev_leds) begin
        n_checks++;
        if (k > 5 || cyc != trans[k] || leds !== nxt[k]) begin
          n_fail++;
          $display("FAIL transition: cycle %0d leds %h, required cycle %0d leds %h",
                   cyc, leds, trans[k % 6], nxt[k % 6]);
        end
        k++;
      end
      prev_leds = leds;
    end
    n_checks++;
    if (k != 6) begin
      n_fail++;
      $display("FAIL transition_count: got %0d, required 6", k);
    end
  endtask

  task automatic test_display();
    int unsigned at  [5] = '{0, 4, 8, 12, 70};
    logic [7:0]  seg [5] = '{8'hC0, 8'hF9, 8'hF9, 8'hFF, 8'hFF};
    logic [3:0]  an  [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1101};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_to(at[i]);
      n_checks++;
      if (seg_display !== seg[i] || anode !== an[i]) begin
        n_fail++;
        $display("FAIL display_%0d: seg %h anode %b, required seg %h anode %b",
                 i, seg_display, anode, seg[i], an[i]);
      end
    end
  endtask

  task automatic test_scan();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (anode !== ANODES[i / 4]) begin
        n_fail++;
        $display("FAIL scan: step %0d got %b, required %b", i, anode, ANODES[i / 4]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int g = 0;
    do_reset();
    run_to(250);
    n_checks++;
    if (leds !== 8'h14) begin
      n_fail++;
      $display("FAIL mid_phase: leds %h, required 14", leds);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (actual() !== RESET_VEC) begin
        n_fail++;
        $display("FAIL mid_reset_%0d: got %h, required %h", i, actual(), RESET_VEC);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    while (leds !== 8'h22 && g < 200) begin
      @(negedge clk);
      g++;
    end
    n_checks++;
    if (g != 100) begin
      n_fail++;
      $display("FAIL post_reset_transition: after %0d cycles, required 100", g);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      int unsigned len;
      do_reset();
      len = $urandom_range(40, 600);
      repeat (len) begin
        @(negedge clk);
        n_checks++;
        if (actual() !== expect_out(cyc)) begin
          n_fail++;
          $display("FAIL random_%0d: cycle %0d got %h, required %h", r, cyc, actual(), expect_out(cyc));
        end
      end
      #($urandom_range(1, 4));
      rst = 1'b1;
      #1;
      n_checks++;
      if (actual() !== RESET_VEC) begin
        n_fail++;
        $display("FAIL random_async_reset_%0d: got %h, required %h", r, actual(), RESET_VEC);
      end
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_divider();
    test_full_cycle();
    test_display();
    test_scan();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
